// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the Wishbone burst initiator.
//   - Cycle type identifiers (CTI) and burst type extension (BTE) codes
//   - Command completion status codes
//   - Initiator FSM state encoding
//   - Helper that picks the CTI for the beat currently on the bus
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_ERR     = 2'b01,
        ST_TIMEOUT = 2'b10
    } status_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP,
        DONE
    } state_t;

    // Classic cycles always advertise 000; incrementing bursts advertise
    // 010 until the final beat, which is tagged end-of-burst.
    function automatic logic [2:0] beat_cti(input logic burst, input logic last);
        if (!burst) begin
            return CTI_CLASSIC;
        end
        return last ? CTI_EOB : CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: per-beat watchdog for the Wishbone initiator.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : restart the count (new beat, ack/err, or not on the bus)
//   enable     : a strobe is outstanding without a response this cycle
//   expire     : high in the TIMEOUT-th consecutive enabled cycle
module wb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // Counts 0..TIMEOUT-1, so $clog2(TIMEOUT) bits suffice (min 1).
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Expiry is flagged in the cycle that would be the TIMEOUT-th waiting
    // cycle, so the initiator drops cyc immediately after it.
    assign expire = enable && (count == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_burst_initiator.sv
// wb_burst_initiator: Wishbone B4 initiator that executes one command as a
// single bus cycle of 1..2**LEN_W beats, either as an incrementing burst
// (CTI 010/111) or as classic single transfers with an idle gap per beat.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   cmd_*                  : command handshake (adr, len = beats-1, we, burst)
//   wr_data/valid/ready    : write beat stream from the source
//   rd_data/valid          : registered read beat stream, no backpressure
//   done, status           : end-of-command pulse, 00 ok / 01 err / 10 timeout
//   wishbone_*             : Wishbone B4 initiator bus
module wb_burst_initiator
    import wb_pkg::*;
#(
    parameter int ADR_W   = 30,
    parameter int DAT_W   = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               cmd_we,
    input  logic               cmd_burst,
    input  logic [DAT_W-1:0]   wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic [DAT_W-1:0]   rd_data,
    output logic               rd_valid,
    output logic               done,
    output logic [1:0]         status,
    output logic [ADR_W-1:0]   wishbone_adr,
    output logic [DAT_W-1:0]   wishbone_dat_w,
    input  logic [DAT_W-1:0]   wishbone_dat_r,
    output logic               wishbone_cyc,
    output logic               wishbone_stb,
    input  logic               wishbone_ack,
    output logic               wishbone_we,
    output logic [DAT_W/8-1:0] wishbone_sel,
    output logic [2:0]         wishbone_cti,
    output logic [1:0]         wishbone_bte,
    input  logic               wishbone_err
);

    state_t           state;
    state_t           next_state;
    logic [ADR_W-1:0] adr_q;
    logic [LEN_W-1:0] rem_q;
    logic             we_q;
    logic             burst_q;
    status_t          status_q;
    logic [DAT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    logic             stb;
    logic             beat_ack;
    logic             beat_err;
    logic             last_beat;
    logic             expire;
    logic             timer_clear;
    logic             timer_enable;

    // rem_q holds beats left minus one, so zero marks the final beat.
    assign last_beat = (rem_q == '0);

    // Responses only count while stb is up; err overrides a simultaneous ack.
    assign beat_err = stb && wishbone_err;
    assign beat_ack = stb && wishbone_ack && !wishbone_err;

    assign timer_clear  = (state != ACTIVE) || beat_ack || beat_err;
    assign timer_enable = stb && !wishbone_ack && !wishbone_err;

    wb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Classic mode inserts a GAP after every ack that is not the last one;
    // burst mode stays in ACTIVE so stalls-free bursts run at one beat/cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (beat_err || expire) begin
                    next_state = DONE;
                end else if (beat_ack) begin
                    if (last_beat) begin
                        next_state = DONE;
                    end else if (!burst_q) begin
                        next_state = GAP;
                    end
                end
            end
            GAP:     next_state = ACTIVE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A write with no beat available becomes a wait state: stb drops while
    // adr and cti hold their values. dat_w passes wr_data through only
    // while a write cycle is open so the bus reads zero otherwise.
    always_comb begin
        cmd_ready      = (state == IDLE) && !reset;
        wishbone_cyc   = (state == ACTIVE) || (state == GAP);
        stb            = (state == ACTIVE) && !(we_q && !wr_valid);
        wishbone_stb   = stb;
        wishbone_cti   = wishbone_cyc ? beat_cti(burst_q, last_beat) : CTI_CLASSIC;
        wishbone_sel   = wishbone_cyc ? '1 : '0;
        wishbone_dat_w = (wishbone_cyc && we_q) ? wr_data : '0;
        wishbone_bte   = BTE_LINEAR;
        wishbone_we    = we_q;
        wishbone_adr   = adr_q;
        wr_ready       = beat_ack && we_q;
        done           = (state == DONE);
        status         = status_q;
        rd_data        = rd_data_q;
        rd_valid       = rd_valid_q;
    end

    // Command latch, address/beat bookkeeping, read capture and the status
    // recorded on the way into DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q      <= '0;
            rem_q      <= '0;
            we_q       <= 1'b0;
            burst_q    <= 1'b0;
            status_q   <= ST_OK;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                adr_q   <= cmd_adr;
                rem_q   <= cmd_len;
                we_q    <= cmd_we;
                burst_q <= cmd_burst;
            end
            if (beat_ack) begin
                adr_q <= adr_q + ADR_W'(1);
                if (!last_beat) begin
                    rem_q <= rem_q - LEN_W'(1);
                end
                if (!we_q) begin
                    rd_data_q  <= wishbone_dat_r;
                    rd_valid_q <= 1'b1;
                end
            end
            if (state == ACTIVE && next_state == DONE) begin
                if (beat_err) begin
                    status_q <= ST_ERR;
                end else if (expire) begin
                    status_q <= ST_TIMEOUT;
                end else begin
                    status_q <= ST_OK;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_burst_initiator.sv
// tb_wb_burst_initiator: directed, table-driven bench for wb_burst_initiator.
// A behavioural SRAM-style responder answers combinationally from stb, a
// write source streams 0xA0, 0xA1, ... and a monitor logs bus activity on
// the falling edge for comparison against hand-computed expectations.
module tb_wb_burst_initiator;

    localparam int ADR_W   = 30;
    localparam int DAT_W   = 32;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [ADR_W-1:0]   cmd_adr;
    logic [LEN_W-1:0]   cmd_len;
    logic               cmd_we;
    logic               cmd_burst;
    logic [DAT_W-1:0]   wr_data;
    logic               wr_valid;
    logic               wr_ready;
    logic [DAT_W-1:0]   rd_data;
    logic               rd_valid;
    logic               done;
    logic [1:0]         status;
    logic [ADR_W-1:0]   wishbone_adr;
    logic [DAT_W-1:0]   wishbone_dat_w;
    logic [DAT_W-1:0]   wishbone_dat_r;
    logic               wishbone_cyc;
    logic               wishbone_stb;
    logic               wishbone_ack;
    logic               wishbone_we;
    logic [DAT_W/8-1:0] wishbone_sel;
    logic [2:0]         wishbone_cti;
    logic [1:0]         wishbone_bte;
    logic               wishbone_err;

    // Responder/source controls
    logic ack_en   = 1'b1;
    int   err_beat = -1;
    int   hold_at  = -1;
    int   hold_len = 0;
    logic tb_clear = 1'b0;
    int   resp_beat = 0;
    int   src_idx   = 0;
    int   hold_cnt  = 0;

    // Monitor log
    int               cyc_no = 0;
    int               n_ack, cyc_cycles, stb_cycles, stall_cycles;
    int               wr_cnt, rd_cnt, done_cnt, last_cyc_no, done_no;
    logic [1:0]       done_status;
    logic [ADR_W-1:0] stall_adr;
    logic [2:0]       stall_cti;
    logic [ADR_W-1:0] obs_adr [16];
    logic [2:0]       obs_cti [16];
    logic [DAT_W-1:0] obs_dat [16];
    logic [DAT_W-1:0] rd_dat  [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADR_W-1:0] adr;
        logic [LEN_W-1:0] len;
        logic             we;
        logic             burst;
        int               err_beat;
        logic             ack_en;
        logic [1:0]       exp_status;
        int               exp_acks;
    } vec_t;

    vec_t vecs [8];

    wb_burst_initiator #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_adr        (cmd_adr),
        .cmd_len        (cmd_len),
        .cmd_we         (cmd_we),
        .cmd_burst      (cmd_burst),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .done           (done),
        .status         (status),
        .wishbone_adr   (wishbone_adr),
        .wishbone_dat_w (wishbone_dat_w),
        .wishbone_dat_r (wishbone_dat_r),
        .wishbone_cyc   (wishbone_cyc),
        .wishbone_stb   (wishbone_stb),
        .wishbone_ack   (wishbone_ack),
        .wishbone_we    (wishbone_we),
        .wishbone_sel   (wishbone_sel),
        .wishbone_cti   (wishbone_cti),
        .wishbone_bte   (wishbone_bte),
        .wishbone_err   (wishbone_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DAT_W-1:0] resp_data(input logic [ADR_W-1:0] a);
        if (a == 30'h20) return 32'h11;
        if (a == 30'h21) return 32'h22;
        return {2'b11, a};
    endfunction

    assign wishbone_ack   = wishbone_stb && ack_en;
    assign wishbone_err   = wishbone_stb && (resp_beat == err_beat);
    assign wishbone_dat_r = resp_data(wishbone_adr);
    assign wr_valid       = !((src_idx == hold_at) && (hold_cnt < hold_len));
    assign wr_data        = 32'(32'hA0 + src_idx);

    // Responder beat counter and write source, advanced on the bus edge.
    always @(posedge clk) begin
        if (tb_clear) begin
            resp_beat <= 0;
            src_idx   <= 0;
            hold_cnt  <= 0;
        end else begin
            if (wishbone_stb && wishbone_ack && !wishbone_err) resp_beat <= resp_beat + 1;
            if (wr_ready) src_idx <= src_idx + 1;
            if (wishbone_cyc && (src_idx == hold_at) && (hold_cnt < hold_len)) hold_cnt <= hold_cnt + 1;
        end
    end

    // Falling-edge monitor: everything is stable half a cycle after the edge.
    always @(negedge clk) begin
        cyc_no <= cyc_no + 1;
        if (tb_clear) begin
            n_ack <= 0; cyc_cycles <= 0; stb_cycles <= 0; stall_cycles <= 0;
            wr_cnt <= 0; rd_cnt <= 0; done_cnt <= 0; done_status <= 2'b11;
            last_cyc_no <= 0; done_no <= 0; stall_adr <= '0; stall_cti <= '0;
        end else begin
            if (wishbone_cyc) begin
                cyc_cycles  <= cyc_cycles + 1;
                last_cyc_no <= cyc_no;
            end
            if (wishbone_stb) stb_cycles <= stb_cycles + 1;
            if (wishbone_cyc && !wishbone_stb) begin
                stall_cycles <= stall_cycles + 1;
                stall_adr    <= wishbone_adr;
                stall_cti    <= wishbone_cti;
            end
            if (wishbone_stb && wishbone_ack && !wishbone_err && n_ack < 16) begin
                obs_adr[n_ack] <= wishbone_adr;
                obs_cti[n_ack] <= wishbone_cti;
                obs_dat[n_ack] <= wishbone_dat_w;
                n_ack <= n_ack + 1;
            end
            if (wr_ready) wr_cnt <= wr_cnt + 1;
            if (rd_valid && rd_cnt < 16) begin
                rd_dat[rd_cnt] <= rd_data;
                rd_cnt <= rd_cnt + 1;
            end
            if (done) begin
                done_cnt    <= done_cnt + 1;
                done_status <= status;
                done_no     <= cyc_no;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Clears logs, then presents one command for a single handshake edge.
    task automatic issueCommand(input logic [ADR_W-1:0] adr, input logic [LEN_W-1:0] len,
                                input logic we, input logic burst);
        @(posedge clk); #1;
        tb_clear = 1'b1;
        @(posedge clk); #1;
        tb_clear  = 1'b0;
        cmd_adr   = adr;
        cmd_len   = len;
        cmd_we    = we;
        cmd_burst = burst;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Bounded wait for done; afterwards cmd_ready must be back.
    task automatic waitDone(input string name);
        int c;
        c = 0;
        while (!done && c < 300) begin
            @(negedge clk);
            c++;
        end
        checkOutput({name, "_done_seen"}, 64'(done), 64'd1);
        @(posedge clk); #1;
        checkOutput({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        ack_en   = v.ack_en;
        err_beat = v.err_beat;
        issueCommand(v.adr, v.len, v.we, v.burst);
        waitDone(name);
        err_beat = -1;
        ack_en   = 1'b1;
    endtask

    task automatic runVector(input vec_t v, input int idx);
        string            nm;
        int               n, exp_stb, exp_cyc;
        logic [ADR_W-1:0] ea;
        logic [2:0]       ec;
        nm = $sformatf("v%0d", idx);
        applyStimulus(v, nm);
        n = int'(v.len) + 1;
        if (!v.ack_en) begin
            exp_stb = TIMEOUT;
            exp_cyc = TIMEOUT;
        end else if (v.err_beat >= 0) begin
            exp_stb = v.err_beat + 1;
            exp_cyc = v.burst ? v.err_beat + 1 : 2 * v.err_beat + 1;
        end else begin
            exp_stb = n;
            exp_cyc = v.burst ? n : 2 * n - 1;
        end
        checkOutput({nm, "_status"},    64'(done_status), 64'(v.exp_status));
        checkOutput({nm, "_done_cnt"},  64'(done_cnt), 64'd1);
        checkOutput({nm, "_acks"},      64'(n_ack), 64'(v.exp_acks));
        checkOutput({nm, "_stb_cyc"},   64'(stb_cycles), 64'(exp_stb));
        checkOutput({nm, "_cyc_cyc"},   64'(cyc_cycles), 64'(exp_cyc));
        checkOutput({nm, "_done_lat"},  64'(done_no - last_cyc_no), 64'd1);
        checkOutput({nm, "_wr_ready"},  64'(wr_cnt), v.we ? 64'(v.exp_acks) : 64'd0);
        checkOutput({nm, "_rd_valid"},  64'(rd_cnt), v.we ? 64'd0 : 64'(v.exp_acks));
        for (int i = 0; i < v.exp_acks && i < 16; i++) begin
            ea = v.adr + ADR_W'(i);
            if (!v.burst)      ec = 3'b000;
            else if (i == n-1) ec = 3'b111;
            else               ec = 3'b010;
            checkOutput($sformatf("%s_adr%0d", nm, i), 64'(obs_adr[i]), 64'(ea));
            checkOutput($sformatf("%s_cti%0d", nm, i), 64'(obs_cti[i]), 64'(ec));
            if (v.we)
                checkOutput($sformatf("%s_datw%0d", nm, i), 64'(obs_dat[i]), 64'(32'hA0 + i));
            else
                checkOutput($sformatf("%s_rdat%0d", nm, i), 64'(rd_dat[i]), 64'(resp_data(ea)));
        end
    endtask

    initial begin
        int c;
        //          adr           len    we    burst err  ack   status  acks
        vecs[0] = '{30'h100,      4'd3, 1'b1, 1'b1, -1, 1'b1, 2'b00, 4};
        vecs[1] = '{30'h20,       4'd1, 1'b0, 1'b0, -1, 1'b1, 2'b00, 2};
        vecs[2] = '{30'h200,      4'd3, 1'b0, 1'b1,  1, 1'b1, 2'b01, 1};
        vecs[3] = '{30'h300,      4'd3, 1'b0, 1'b1, -1, 1'b0, 2'b10, 0};
        vecs[4] = '{30'h3FFFFFFE, 4'd3, 1'b0, 1'b1, -1, 1'b1, 2'b00, 4};
        vecs[5] = '{30'h55,       4'd0, 1'b1, 1'b1, -1, 1'b1, 2'b00, 1};
        vecs[6] = '{30'h40,       4'd2, 1'b1, 1'b0, -1, 1'b1, 2'b00, 3};
        vecs[7] = '{30'h60,       4'd2, 1'b1, 1'b1,  0, 1'b1, 2'b01, 0};

        cmd_valid = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_we = 1'b0; cmd_burst = 1'b0;
        reset = 1'b1;
        #3;
        checkOutput("rst_cyc",      64'(wishbone_cyc), 64'd0);
        checkOutput("rst_stb",      64'(wishbone_stb), 64'd0);
        checkOutput("rst_we",       64'(wishbone_we), 64'd0);
        checkOutput("rst_done",     64'(done), 64'd0);
        checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("rst_wr_ready", 64'(wr_ready), 64'd0);
        checkOutput("rst_adr",      64'(wishbone_adr), 64'd0);
        checkOutput("rst_dat_w",    64'(wishbone_dat_w), 64'd0);
        checkOutput("rst_cti",      64'(wishbone_cti), 64'd0);
        checkOutput("rst_status",   64'(status), 64'd0);
        checkOutput("rst_bte",      64'(wishbone_bte), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i], i);
        end

        // Write burst with the source stalling three cycles before beat 2.
        hold_at  = 1;
        hold_len = 3;
        issueCommand(30'h100, 4'd3, 1'b1, 1'b1);
        waitDone("ws");
        hold_at  = -1;
        hold_len = 0;
        checkOutput("ws_stall_cycles", 64'(stall_cycles), 64'd3);
        checkOutput("ws_stall_adr",    64'(stall_adr), 64'h101);
        checkOutput("ws_stall_cti",    64'(stall_cti), 64'h2);
        checkOutput("ws_acks",         64'(n_ack), 64'd4);
        checkOutput("ws_wr_ready",     64'(wr_cnt), 64'd4);
        checkOutput("ws_cyc_cycles",   64'(cyc_cycles), 64'd7);
        checkOutput("ws_status",       64'(done_status), 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ws_adr%0d", i),  64'(obs_adr[i]), 64'(30'h100 + i));
            checkOutput($sformatf("ws_datw%0d", i), 64'(obs_dat[i]), 64'(32'hA0 + i));
        end

        // Reset asserted while beat 2 of a burst read is on the bus.
        issueCommand(30'h300, 4'd3, 1'b0, 1'b1);
        c = 0;
        while (!(wishbone_stb && resp_beat == 1) && c < 50) begin
            @(negedge clk);
            c++;
        end
        checkOutput("mr_reached_beat2", 64'(wishbone_stb && resp_beat == 1), 64'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("mr_cyc_async", 64'(wishbone_cyc), 64'd0);
        checkOutput("mr_stb_async", 64'(wishbone_stb), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("mr_no_done",   64'(done_cnt), 64'd0);
        checkOutput("mr_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("mr_cyc_idle",  64'(wishbone_cyc), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
